// File: rtl/ram_io_responder_if.sv
// Bundled memory-controller bus and host byte streams of the RAM/IO responder.
// The master drives requests and host-side handshakes; the slave is the responder.
interface ram_io_responder_if;
    logic        rdy;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        sim_halt;
    logic        tx_overflow;

    modport master (
        output rdy, mem_a, mem_dout, mem_wr, tx_ready, rx_valid, rx_data,
        input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, sim_halt, tx_overflow
    );

    modport slave (
        input  rdy, mem_a, mem_dout, mem_wr, tx_ready, rx_valid, rx_data,
        output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, sim_halt, tx_overflow
    );
endinterface

// File: rtl/ram_io_responder.sv
// Byte-wide RAM plus memory-mapped IO (TX/RX byte FIFOs, halt) behind a 1-cycle
// load-latency memory port. RAM contents survive reset; FIFOs and flags do not.
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_io_responder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_NEAR_C  = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO_C  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE_C   = PTR_W'(1);
    localparam logic [17:0]      IO_DATA_A_C = 18'h30000;
    localparam logic [17:0]      IO_CTRL_A_C = 18'h30004;

    logic [7:0]            ram_r    [0:(2**ADDR_WIDTH)-1];
    logic [7:0]            tx_mem_r [0:FIFO_DEPTH-1];
    logic [7:0]            rx_mem_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]      tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
    logic [CNT_W-1:0]      tx_cnt_r, rx_cnt_r;
    logic [7:0]            mem_din_r;
    logic                  sim_halt_r, tx_overflow_r;

    logic                  is_io_s;
    logic [ADDR_WIDTH-1:0] ram_idx_s;
    logic                  tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic                  ram_we_s, tx_push_s, tx_pop_s, tx_drop_s;
    logic                  rx_push_s, rx_pop_s, halt_set_s;
    logic [7:0]            load_data_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^bus.mem_a[31:18];

    // Address decode and per-cycle access strobes; memory side is gated by rdy.
    always_comb begin
        tx_empty_s  = (tx_cnt_r == CNT_ZERO_C);
        tx_full_s   = (tx_cnt_r == CNT_FULL_C);
        rx_empty_s  = (rx_cnt_r == CNT_ZERO_C);
        rx_full_s   = (rx_cnt_r == CNT_FULL_C);
        is_io_s     = (bus.mem_a[17:16] == 2'b11);
        ram_idx_s   = bus.mem_a[ADDR_WIDTH-1:0];
        tx_pop_s    = !tx_empty_s && bus.tx_ready;
        rx_push_s   = bus.rx_valid && !rx_full_s;
        ram_we_s    = 1'b0;
        tx_push_s   = 1'b0;
        tx_drop_s   = 1'b0;
        rx_pop_s    = 1'b0;
        halt_set_s  = 1'b0;
        load_data_s = 8'h00;
        if (bus.rdy) begin
            if (bus.mem_wr) begin
                if (!is_io_s) begin
                    ram_we_s = 1'b1;
                end else if (bus.mem_a[17:0] == IO_DATA_A_C) begin
                    // A full FIFO still accepts the byte when the host frees a slot this cycle.
                    if (!tx_full_s || tx_pop_s) begin
                        tx_push_s = 1'b1;
                    end else begin
                        tx_drop_s = 1'b1;
                    end
                end else if (bus.mem_a[17:0] == IO_CTRL_A_C) begin
                    halt_set_s = 1'b1;
                end else begin
                    halt_set_s = 1'b0;
                end
            end else begin
                if (!is_io_s) begin
                    load_data_s = ram_r[ram_idx_s];
                end else if (bus.mem_a[17:0] == IO_DATA_A_C) begin
                    if (!rx_empty_s) begin
                        rx_pop_s    = 1'b1;
                        load_data_s = rx_mem_r[rx_rp_r];
                    end else begin
                        load_data_s = 8'h00;
                    end
                end else if (bus.mem_a[17:0] == IO_CTRL_A_C) begin
                    load_data_s = {7'b0000000, tx_empty_s};
                end else begin
                    load_data_s = 8'h00;
                end
            end
        end else begin
            load_data_s = 8'h00;
        end
    end

    // RAM array write port; deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (rst && ram_we_s) begin
            ram_r[ram_idx_s] <= bus.mem_dout;
        end
    end

    // FIFO storage write ports.
    always_ff @(posedge clk) begin
        if (rst && tx_push_s) begin
            tx_mem_r[tx_wp_r] <= bus.mem_dout;
        end
        if (rst && rx_push_s) begin
            rx_mem_r[rx_wp_r] <= bus.rx_data;
        end
    end

    // Pointers, counts, load return register and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp_r       <= PTR_ZERO_C;
            tx_rp_r       <= PTR_ZERO_C;
            rx_wp_r       <= PTR_ZERO_C;
            rx_rp_r       <= PTR_ZERO_C;
            tx_cnt_r      <= CNT_ZERO_C;
            rx_cnt_r      <= CNT_ZERO_C;
            mem_din_r     <= 8'h00;
            sim_halt_r    <= 1'b0;
            tx_overflow_r <= 1'b0;
        end else begin
            if (tx_push_s) tx_wp_r <= tx_wp_r + PTR_ONE_C;
            if (tx_pop_s)  tx_rp_r <= tx_rp_r + PTR_ONE_C;
            if (rx_push_s) rx_wp_r <= rx_wp_r + PTR_ONE_C;
            if (rx_pop_s)  rx_rp_r <= rx_rp_r + PTR_ONE_C;
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_cnt_r <= tx_cnt_r + CNT_ONE_C;
                2'b01:   tx_cnt_r <= tx_cnt_r - CNT_ONE_C;
                default: tx_cnt_r <= tx_cnt_r;
            endcase
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_cnt_r <= rx_cnt_r + CNT_ONE_C;
                2'b01:   rx_cnt_r <= rx_cnt_r - CNT_ONE_C;
                default: rx_cnt_r <= rx_cnt_r;
            endcase
            if (bus.rdy)   mem_din_r     <= load_data_s;
            if (halt_set_s) sim_halt_r   <= 1'b1;
            if (tx_drop_s) tx_overflow_r <= 1'b1;
        end
    end

    assign bus.mem_din        = mem_din_r;
    assign bus.io_buffer_full = (tx_cnt_r >= CNT_NEAR_C);
    assign bus.tx_valid       = !tx_empty_s;
    assign bus.tx_data        = tx_mem_r[tx_rp_r];
    assign bus.rx_ready       = !rx_full_s;
    assign bus.sim_halt       = sim_halt_r;
    assign bus.tx_overflow    = tx_overflow_r;
endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios plus a randomized
// run, all compared against a queue/associative-array reference model.
module tb_ram_io_responder;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ram_io_responder_if bus();

    ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] ram_m [int];
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic [7:0] din_m     = 8'h00;
    bit         din_known = 1'b1;
    bit         halt_m    = 1'b0;
    bit         ovf_m     = 1'b0;

    task automatic drive(input bit rdy_v, input bit wr_v, input logic [31:0] a_v, input logic [7:0] d_v);
        bus.rdy      = rdy_v;
        bus.mem_wr   = wr_v;
        bus.mem_a    = a_v;
        bus.mem_dout = d_v;
    endtask

    // Applies one clock of the documented behaviour to the model, using current inputs.
    task automatic model_step();
        int          tsz;
        int          rsz;
        bit          tpop;
        logic [17:0] off;
        tsz = txq.size();
        rsz = rxq.size();
        if (!rst) begin
            txq.delete();
            rxq.delete();
            din_m = 8'h00; din_known = 1'b1; halt_m = 1'b0; ovf_m = 1'b0;
        end else begin
            off  = bus.mem_a[17:0];
            tpop = (tsz > 0) && bus.tx_ready;
            if (tpop) txq.delete(0);
            if (bus.rdy) begin
                din_known = 1'b1;
                if (bus.mem_wr) begin
                    din_m = 8'h00;
                    if (off[17:16] != 2'b11) ram_m[int'(off[16:0])] = bus.mem_dout;
                    else if (off == 18'h30000) begin
                        if (tsz < DEPTH || tpop) txq.push_back(bus.mem_dout);
                        else ovf_m = 1'b1;
                    end else if (off == 18'h30004) halt_m = 1'b1;
                end else begin
                    if (off[17:16] != 2'b11) begin
                        if (ram_m.exists(int'(off[16:0]))) din_m = ram_m[int'(off[16:0])];
                        else din_known = 1'b0;
                    end else if (off == 18'h30000) begin
                        if (rsz > 0) begin
                            din_m = rxq[0];
                            rxq.delete(0);
                        end else din_m = 8'h00;
                    end else if (off == 18'h30004) din_m = (tsz == 0) ? 8'h01 : 8'h00;
                    else din_m = 8'h00;
                end
            end
            if (bus.rx_valid && rsz < DEPTH) rxq.push_back(bus.rx_data);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h77);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h99; bus.tx_ready = 1'b0;
        tick(); tick();
        total++; if (bus.mem_din !== 8'h00) begin bad++; $display("FAIL reset_mem_din got=%h exp=00", bus.mem_din); end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
        total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b exp=1", bus.rx_ready); end
        total++; if (bus.sim_halt !== 1'b0) begin bad++; $display("FAIL reset_sim_halt got=%b exp=0", bus.sim_halt); end
        total++; if (bus.tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_tx_overflow got=%b exp=0", bus.tx_overflow); end
        total++; if (bus.io_buffer_full !== 1'b0) begin bad++; $display("FAIL reset_io_full got=%b exp=0", bus.io_buffer_full); end
        rst = 1'b1; bus.rx_valid = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        tick();
    endtask

    task automatic test_ram();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00); tick();
        total++; if (bus.mem_din !== 8'h01) begin bad++; $display("FAIL ram_txempty got=%h exp=01", bus.mem_din); end
        drive(1'b1, 1'b1, 32'h0000_0100, 8'hA5); tick();
        total++; if (bus.mem_din !== 8'h00) begin bad++; $display("FAIL ram_store_din got=%h exp=00", bus.mem_din); end
        drive(1'b1, 1'b0, 32'h0000_0100, 8'h00); tick();
        total++; if (bus.mem_din !== 8'hA5) begin bad++; $display("FAIL ram_load got=%h exp=a5", bus.mem_din); end
        drive(1'b1, 1'b1, 32'h0000_0101, 8'h3C); tick();
        drive(1'b1, 1'b0, 32'hFFFC_0100, 8'h00); tick();
        total++; if (bus.mem_din !== 8'hA5) begin bad++; $display("FAIL ram_alias got=%h exp=a5", bus.mem_din); end
        drive(1'b1, 1'b0, 32'h0000_0101, 8'h00); tick();
        total++; if (bus.mem_din !== 8'h3C) begin bad++; $display("FAIL ram_load2 got=%h exp=3c", bus.mem_din); end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_tx_backpressure();
        logic [7:0] b [9];
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b[i] = 8'($urandom);
            drive(1'b1, 1'b1, 32'h0003_0000, b[i]); tick();
            if (i < 8) begin
                total++;
                if (bus.io_buffer_full !== (i >= 6)) begin bad++; $display("FAIL bp_io_full i=%0d got=%b exp=%b", i, bus.io_buffer_full, (i >= 6)); end
                total++;
                if (bus.tx_overflow !== 1'b0) begin bad++; $display("FAIL bp_no_ovf i=%0d got=%b exp=0", i, bus.tx_overflow); end
            end
        end
        total++; if (bus.tx_overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b exp=1", bus.tx_overflow); end
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00); tick();
        total++; if (bus.mem_din !== 8'h00) begin bad++; $display("FAIL bp_txempty got=%h exp=00", bus.mem_din); end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== b[i]) begin
                bad++; $display("FAIL bp_drain i=%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, b[i]);
            end
            tick();
        end
        bus.tx_ready = 1'b0;
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", bus.tx_valid); end
        total++; if (bus.io_buffer_full !== 1'b0) begin bad++; $display("FAIL bp_io_clear got=%b exp=0", bus.io_buffer_full); end
    endtask

    task automatic test_rx();
        logic [7:0] d [8];
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h11; tick();
        bus.rx_data = 8'h22; tick();
        bus.rx_valid = 1'b0;
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00); tick();
        total++; if (bus.mem_din !== 8'h11) begin bad++; $display("FAIL rx_first got=%h exp=11", bus.mem_din); end
        tick();
        total++; if (bus.mem_din !== 8'h22) begin bad++; $display("FAIL rx_second got=%h exp=22", bus.mem_din); end
        tick();
        total++; if (bus.mem_din !== 8'h00) begin bad++; $display("FAIL rx_empty got=%h exp=00", bus.mem_din); end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h33; tick();
        bus.rx_valid = 1'b0;
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00); tick();
        total++; if (bus.mem_din !== 8'h33) begin bad++; $display("FAIL rx_after_empty got=%h exp=33", bus.mem_din); end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.rx_data = 8'($urandom);
            if (i < 8) d[i] = bus.rx_data;
            tick();
        end
        bus.rx_valid = 1'b0;
        total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL rx_full got=%b exp=0", bus.rx_ready); end
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00);
        for (int i = 0; i < 9; i++) begin
            tick();
            total++;
            if (bus.mem_din !== ((i < 8) ? d[i] : 8'h00)) begin
                bad++; $display("FAIL rx_drain i=%0d got=%h exp=%h", i, bus.mem_din, (i < 8) ? d[i] : 8'h00);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_wrap();
        logic [7:0] sent [$];
        logic [7:0] exp8 [8];
        int pushed = 0;
        int popped = 0;
        rst = 1'b0; drive(1'b0, 1'b0, 32'h0, 8'h00); tick(); rst = 1'b1;
        for (int cyc = 0; cyc < 300 && popped < 20; cyc++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            if (pushed < 20 && txq.size() < DEPTH - 1) begin
                drive(1'b1, 1'b1, 32'h0003_0000, 8'(pushed * 13 + 7));
                sent.push_back(8'(pushed * 13 + 7));
                pushed++;
            end else drive(1'b0, 1'b0, 32'h0, 8'h00);
            if (bus.tx_valid && bus.tx_ready) begin
                total++;
                if (popped >= sent.size() || bus.tx_data !== sent[popped]) begin
                    bad++; $display("FAIL wrap_order n=%0d got=%h", popped, bus.tx_data);
                end
                popped++;
            end
            tick();
        end
        total++; if (popped != 20) begin bad++; $display("FAIL wrap_count got=%0d exp=20", popped); end
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'(8'h80 + i)); tick();
        end
        total++; if (bus.io_buffer_full !== 1'b1) begin bad++; $display("FAIL full_io got=%b exp=1", bus.io_buffer_full); end
        drive(1'b1, 1'b1, 32'h0003_0000, 8'hEE); bus.tx_ready = 1'b1;
        total++; if (bus.tx_data !== 8'h80) begin bad++; $display("FAIL full_head got=%h exp=80", bus.tx_data); end
        tick();
        total++; if (bus.tx_overflow !== 1'b0) begin bad++; $display("FAIL full_pp_ovf got=%b exp=0", bus.tx_overflow); end
        total++; if (bus.io_buffer_full !== 1'b1) begin bad++; $display("FAIL full_pp_io got=%b exp=1", bus.io_buffer_full); end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 7; i++) exp8[i] = 8'(8'h81 + i);
        exp8[7] = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp8[i]) begin
                bad++; $display("FAIL full_drain i=%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, exp8[i]);
            end
            tick();
        end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL full_count got=%b exp=0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_rdy_halt();
        drive(1'b1, 1'b1, 32'h0000_0200, 8'h5A); tick();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00); tick();
        total++; if (bus.mem_din !== 8'h01) begin bad++; $display("FAIL rdy_pre got=%h exp=01", bus.mem_din); end
        drive(1'b0, 1'b1, 32'h0000_0200, 8'hFF); tick();
        total++; if (bus.mem_din !== 8'h01) begin bad++; $display("FAIL rdy_hold got=%h exp=01", bus.mem_din); end
        drive(1'b0, 1'b1, 32'h0003_0004, 8'h00); tick();
        total++; if (bus.sim_halt !== 1'b0) begin bad++; $display("FAIL rdy_no_halt got=%b exp=0", bus.sim_halt); end
        drive(1'b0, 1'b1, 32'h0003_0000, 8'h44); tick();
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rdy_no_push got=%b exp=0", bus.tx_valid); end
        drive(1'b1, 1'b0, 32'h0000_0200, 8'h00); tick();
        total++; if (bus.mem_din !== 8'h5A) begin bad++; $display("FAIL rdy_ram_kept got=%h exp=5a", bus.mem_din); end
        drive(1'b1, 1'b1, 32'h0003_0008, 8'h00); tick();
        total++; if (bus.sim_halt !== 1'b0 || bus.tx_valid !== 1'b0) begin
            bad++; $display("FAIL io_other got=%b/%b exp=0/0", bus.sim_halt, bus.tx_valid);
        end
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h00); tick();
        total++; if (bus.sim_halt !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", bus.sim_halt); end
        drive(1'b0, 1'b0, 32'h0, 8'h00); tick(); tick(); tick();
        total++; if (bus.sim_halt !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b exp=1", bus.sim_halt); end
        rst = 1'b0; tick(); rst = 1'b1;
        total++; if (bus.sim_halt !== 1'b0) begin bad++; $display("FAIL halt_reset got=%b exp=0", bus.sim_halt); end
    endtask

    task automatic test_reset_midop();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'(i + 1)); tick();
        end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h5C; tick(); bus.rx_valid = 1'b0;
        total++; if (bus.tx_valid !== 1'b1) begin bad++; $display("FAIL mid_queued got=%b exp=1", bus.tx_valid); end
        rst = 1'b0; tick();
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL mid_tx_valid got=%b exp=0", bus.tx_valid); end
        total++; if (bus.io_buffer_full !== 1'b0) begin bad++; $display("FAIL mid_io_full got=%b exp=0", bus.io_buffer_full); end
        total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL mid_rx_ready got=%b exp=1", bus.rx_ready); end
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0100, 8'h00); tick();
        total++; if (bus.mem_din !== 8'hA5) begin bad++; $display("FAIL mid_ram_kept got=%h exp=a5", bus.mem_din); end
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00); tick();
        total++; if (bus.mem_din !== 8'h00) begin bad++; $display("FAIL mid_rx_flushed got=%h exp=00", bus.mem_din); end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [17:0] off;
        int          sel;
        for (int n = 0; n < 600; n++) begin
            r   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: off = 18'h00400 + 18'(sel);
                4:          off = 18'h2FFFF;
                5, 6:       off = 18'h30000;
                7:          off = 18'h30004;
                8:          off = 18'h30008;
                default:    off = 18'h3FFFF;
            endcase
            rst          = ($urandom_range(0, 99) != 0);
            bus.tx_ready = ($urandom_range(0, 2) == 0);
            bus.rx_valid = 1'($urandom_range(0, 1));
            bus.rx_data  = 8'($urandom);
            drive(($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), {r[31:18], off}, 8'($urandom));
            tick();
            if (din_known) begin
                total++;
                if (bus.mem_din !== din_m) begin bad++; $display("FAIL rnd_din n=%0d got=%h exp=%h", n, bus.mem_din, din_m); end
            end
            total++;
            if (bus.tx_valid !== (txq.size() != 0)) begin bad++; $display("FAIL rnd_tx_valid n=%0d got=%b exp=%b", n, bus.tx_valid, (txq.size() != 0)); end
            if (txq.size() != 0) begin
                total++;
                if (bus.tx_data !== txq[0]) begin bad++; $display("FAIL rnd_tx_data n=%0d got=%h exp=%h", n, bus.tx_data, txq[0]); end
            end
            total++;
            if (bus.rx_ready !== (rxq.size() < DEPTH)) begin bad++; $display("FAIL rnd_rx_ready n=%0d got=%b", n, bus.rx_ready); end
            total++;
            if (bus.io_buffer_full !== (txq.size() >= DEPTH - 1)) begin bad++; $display("FAIL rnd_io_full n=%0d got=%b", n, bus.io_buffer_full); end
            total++;
            if (bus.sim_halt !== halt_m || bus.tx_overflow !== ovf_m) begin
                bad++; $display("FAIL rnd_flags n=%0d got=%b%b exp=%b%b", n, bus.sim_halt, bus.tx_overflow, halt_m, ovf_m);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        test_reset();
        test_ram();
        test_tx_backpressure();
        test_rx();
        test_wrap();
        test_rdy_halt();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
